// File: rtl/aim_sched_pkg.sv
// aim_sched_pkg: shared types and default sizing for the AIM iteration
// scheduler (aim_iter_sched) and its helpers.
//   sched_state_e : scheduler FSM states
//   DEF_*         : default block parameters
//   LANE_IDX_W    : lane index width for the default lane count
//   HIT_CNT_W     : hit counter width, holds LANES * 2^ITE_W without saturating
package aim_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } sched_state_e;

  localparam int DEF_LANES   = 32;
  localparam int DEF_POS_W   = 9;
  localparam int DEF_ITE_W   = 3;
  localparam int DEF_TIMEOUT = 1024;

  localparam int LANE_IDX_W = $clog2(DEF_LANES);
  localparam int HIT_CNT_W  = LANE_IDX_W + DEF_ITE_W + 1;

endpackage

// File: rtl/lowest_set_enc.sv
// lowest_set_enc: combinational priority encoder, lowest set bit wins.
//   vec : input bit vector
//   any : high when any bit of vec is set
//   idx : index of the lowest set bit (0 when vec is all zero)
module lowest_set_enc #(
  parameter int N     = 32,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the last assignment is the lowest set bit.
  always_comb begin
    any = |vec;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/aim_iter_sched.sv
// aim_iter_sched: runs AIM once per iteration for a programmed number of
// iterations, then serialises each iteration's valid lanes into a
// valid/ready hit stream.
//   i_clk, i_rst          : clock, async active-high reset
//   i_start, i_num_ite    : run request (IDLE only), iterations (0 means 2^ITE_W)
//   o_aim_start, o_aim_ite: AIM launch pulse and iteration index
//   i_aim_finish, i_aim_valid, i_aim_pos : AIM completion and per-lane results
//   o_hit_valid, i_hit_ready, o_hit_pos, o_hit_lane, o_hit_ite : hit stream
//   o_hit_cnt             : hits transferred in the current/last run
//   o_busy, o_done, o_err : status, end-of-run pulse, sticky timeout
//
// state  | meaning
// IDLE   | waiting for i_start
// LAUNCH | one-cycle AIM start pulse for the current iteration
// WAIT   | waiting for AIM finish, timeout counter running
// DRAIN  | streaming the captured lanes, lowest lane first
// DONE   | one-cycle end-of-run pulse
module aim_iter_sched
  import aim_sched_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int POS_W   = DEF_POS_W,
  parameter int ITE_W   = DEF_ITE_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic [ITE_W-1:0]                 i_num_ite,
  output logic                             o_aim_start,
  output logic [ITE_W-1:0]                 o_aim_ite,
  input  logic                             i_aim_finish,
  input  logic [LANES-1:0]                 i_aim_valid,
  input  logic [LANES*POS_W-1:0]           i_aim_pos,
  output logic                             o_hit_valid,
  input  logic                             i_hit_ready,
  output logic [POS_W-1:0]                 o_hit_pos,
  output logic [$clog2(LANES)-1:0]         o_hit_lane,
  output logic [ITE_W-1:0]                 o_hit_ite,
  output logic [$clog2(LANES)+ITE_W:0]     o_hit_cnt,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err
);

  localparam int LIDX_W = $clog2(LANES);
  localparam int CNT_W  = LIDX_W + ITE_W + 1;
  localparam int NUM_W  = ITE_W + 1;
  localparam int TCNT_W = $clog2(TIMEOUT);

  sched_state_e state, state_nxt;

  logic [NUM_W-1:0]       num_ite;
  logic [ITE_W-1:0]       ite, ite_nxt;
  logic [CNT_W-1:0]       hit_cnt;
  logic                   err;
  logic [LANES-1:0]       mask, mask_rest;
  logic [LANES*POS_W-1:0] pos_snap;
  logic [TCNT_W-1:0]      tcnt;
  logic                   aim_start_q;
  logic [ITE_W-1:0]       aim_ite_q;
  logic                   done_q;

  logic                   any_hit;
  logic [LIDX_W-1:0]      hit_idx;
  logic                   hit_valid;
  logic                   fire;
  logic                   last_ite;
  logic                   accept;
  logic                   capture;
  logic                   tmo;

  lowest_set_enc #(
    .N     (LANES),
    .IDX_W (LIDX_W)
  ) u_enc (
    .vec (mask),
    .any (any_hit),
    .idx (hit_idx)
  );

  assign hit_valid = (state == DRAIN) && any_hit;
  assign fire      = hit_valid && i_hit_ready;
  assign last_ite  = ({1'b0, ite} == (num_ite - NUM_W'(1)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ite_nxt   = ite;
    accept    = 1'b0;
    capture   = 1'b0;
    tmo       = 1'b0;
    mask_rest = mask;
    if (fire) mask_rest[hit_idx] = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) begin
          accept    = 1'b1;
          ite_nxt   = '0;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (i_aim_finish) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
        end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
          tmo       = 1'b1;
          state_nxt = DONE;
        end
      end
      DRAIN: begin
        // Decide on the mask as it will be after this cycle's transfer so the
        // last hit and the state change share a cycle.
        if (mask_rest == '0) begin
          if (last_ite) begin
            state_nxt = DONE;
          end else begin
            ite_nxt   = ite + 1'b1;
            state_nxt = LAUNCH;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      num_ite     <= '0;
      ite         <= '0;
      hit_cnt     <= '0;
      err         <= 1'b0;
      mask        <= '0;
      pos_snap    <= '0;
      tcnt        <= '0;
      aim_start_q <= 1'b0;
      aim_ite_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      ite         <= ite_nxt;
      aim_start_q <= (state_nxt == LAUNCH);
      done_q      <= (state_nxt == DONE);
      if (state_nxt == LAUNCH) aim_ite_q <= ite_nxt;

      if (accept) begin
        num_ite <= (i_num_ite == '0) ? NUM_W'(1 << ITE_W) : {1'b0, i_num_ite};
        hit_cnt <= '0;
        err     <= 1'b0;
      end else if (fire) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      if (tmo) err <= 1'b1;

      if (state == LAUNCH)    tcnt <= '0;
      else if (state == WAIT) tcnt <= tcnt + 1'b1;

      if (capture) begin
        mask     <= i_aim_valid;
        pos_snap <= i_aim_pos;
      end else begin
        mask <= mask_rest;
      end
    end
  end

  assign o_aim_start = aim_start_q;
  assign o_aim_ite   = aim_ite_q;
  assign o_hit_valid = hit_valid;
  assign o_hit_lane  = hit_valid ? hit_idx : '0;
  assign o_hit_pos   = hit_valid ? pos_snap[hit_idx*POS_W +: POS_W] : '0;
  assign o_hit_ite   = hit_valid ? ite : '0;
  assign o_hit_cnt   = hit_cnt;
  assign o_busy      = (state != IDLE);
  assign o_done      = done_q;
  assign o_err       = err;

endmodule

// File: doc/aim_iter_sched.md
Name: aim_iter_sched

Overview:
- Sequencer for the AIM matching datapath. On one top-level start it runs AIM once per iteration, for a programmed number of iterations, pulsing AIM's start and driving its iteration index.
- After each AIM finish it snapshots AIM's per-lane valid/pos outputs and serialises the valid lanes into a valid/ready hit stream for the downstream tracker logic.
- Reports busy, done, total hit count, and a timeout error if AIM never finishes.

Parameters:
- LANES, 32, number of AIM output lanes (valid/pos pairs)
- POS_W, 9, width of each lane position
- ITE_W, 3, width of the iteration index
- TIMEOUT, 1024, max cycles to wait for AIM finish after a launch

Ports:
- i_clk  in  1  clock. One clock domain only.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle request to start a run. Honoured only in IDLE.
- i_num_ite  in  ITE_W  iterations per run. Value 0 means 2^ITE_W (8). Sampled when i_start is accepted.
- o_aim_start  out  1  one-cycle start pulse to AIM.
- o_aim_ite  out  ITE_W  iteration index to AIM. Held stable from the launch cycle until the next launch.
- i_aim_finish  in  1  AIM completion pulse.
- i_aim_valid  in  LANES  per-lane valid from AIM.
- i_aim_pos  in  LANES*POS_W  packed lane positions; lane k occupies bits [k*POS_W +: POS_W].
- o_hit_valid  out  1  hit stream valid.
- i_hit_ready  in  1  hit stream ready.
- o_hit_pos  out  POS_W  position of the current hit.
- o_hit_lane  out  $clog2(LANES)  lane index of the current hit.
- o_hit_ite  out  ITE_W  iteration that produced the current hit.
- o_hit_cnt  out  $clog2(LANES)+ITE_W+1  hits transferred in the current or last run.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse at the end of a run.
- o_err  out  1  sticky timeout flag; cleared when the next i_start is accepted.

Behaviour:
- Reset: every output is 0, state is IDLE, snapshot mask is 0, counters are 0. Reset asserted mid-run aborts the run immediately and leaves no pending AIM start.
- States: IDLE, LAUNCH, WAIT, DRAIN, DONE.
- IDLE:
  - i_start=1 latches num_ite (0 becomes 8), clears ite, o_hit_cnt and o_err, then goes to LAUNCH.
  - i_start is ignored in every other state.
- LAUNCH (1 cycle): o_aim_start=1 and o_aim_ite=ite, both registered; the timeout counter is cleared; next state is WAIT.
  - Latency: i_start at cycle N gives o_aim_start high at cycle N+1.
- WAIT:
  - i_aim_finish=1 captures i_aim_valid into the mask and i_aim_pos into the pos snapshot, then goes to DRAIN.
  - Otherwise the counter increments. When it reaches TIMEOUT-1, o_err is set and the state goes to DONE.
  - i_aim_finish is ignored outside WAIT.
- DRAIN:
  - A combinational priority encoder selects the lowest set mask bit k.
  - o_hit_valid = |mask; o_hit_lane = k; o_hit_pos = snapshot[k]; o_hit_ite = ite.
  - On valid&&ready: clear mask bit k and increment o_hit_cnt. One hit transfers per cycle at most.
  - Outputs hold stable while valid&&!ready.
  - When the mask is 0, including an all-zero capture (zero cycles of o_hit_valid): if ite == num_ite-1 go to DONE; otherwise increment ite and go to LAUNCH.
- DONE (1 cycle): o_done=1, then IDLE. o_hit_cnt and o_err hold until the next accepted start.
- Width rules:
  - ite counts 0..num_ite-1 with no wrap; a full 8-iteration run ends at ite=7.
  - o_hit_cnt max is LANES*8 = 256 and needs 9 bits, so it never saturates.
- Throughput: per iteration, 1 launch cycle + AIM latency + max(1, hits) drain cycles with ready held high.

Decomposition:
- Package aim_sched_pkg holds:
  - state enum sched_state_e {IDLE, LAUNCH, WAIT, DRAIN, DONE};
  - localparams for LANE_IDX_W and HIT_CNT_W;
  - default TIMEOUT.
- One sub-module, lowest_set_enc: LANES-bit input, outputs any-set and the index of the lowest set bit; purely combinational.

Test Plan:
- Single iteration: num_ite=1, AIM finishes with valid=0x0000_0005, pos[0]=3, pos[2]=7, ready held 1. Required: hits (lane0,pos3,ite0) then (lane2,pos7,ite0) on consecutive cycles, o_done one cycle later, o_hit_cnt=2.
- Multi-iteration with backpressure: num_ite=3, each finish has valid=0x8000_0001, ready toggles 1/0. Required: o_aim_ite sequence 0,1,2; 6 hits total, lane order 0 then 31 per iteration; outputs stable while ready=0; o_hit_cnt=6.
- Empty iteration and num_ite=0: every valid=0. Required: 8 launches with o_aim_ite 0..7, no o_hit_valid, o_done once, o_hit_cnt=0.
- Timeout: AIM never finishes. Required: o_err=1 and o_done exactly TIMEOUT cycles after WAIT entry; next i_start clears o_err.
- Start while busy and stray finish: i_start during DRAIN and i_aim_finish during IDLE/DRAIN. Required: both ignored, no extra launch, hit stream unchanged.
- Reset mid-DRAIN: assert i_rst with 5 hits pending. Required: all outputs 0 on the same edge, IDLE; a new run starts cleanly with o_hit_cnt=0.
